serial_adder: RTL and testbench

// - Bit-serial N-bit adder: the sequential stage wrapped around the team's half_adder cell.
// - Latches two WIDTH-bit operands, adds one bit pair per clock, LSB first.
// - Each bit uses two half_adder instances plus an OR, with a registered carry between bits.
// - Returns the WIDTH-bit sum and carry-out with a start/busy/done handshake.
// - Trades WIDTH cycles of latency for a single-bit datapath.

---
 rtl/serial_adder.sv | 127 ++++++++++++
 tb/tb_serial_adder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder built from two half_adder cells per bit, with start/busy/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVERFLOW_EN.

module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_sum,
  output logic o_carry
);
  assign o_sum   = i_a ^ i_b;
  assign o_carry = i_a & i_b;
endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
`ifdef SERIAL_ADDER_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_sum, w_sum_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_c, r_carry;
  logic             w_last, w_s0, w_c0, w_s, w_c1, w_cnext;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic             r_ovf;
`endif

  half_adder u_ha0 (.i_a(r_a[0]), .i_b(r_b[0]), .o_sum(w_s0), .o_carry(w_c0));
  half_adder u_ha1 (.i_a(w_s0),   .i_b(r_c),    .o_sum(w_s),  .o_carry(w_c1));

  assign w_cnext = w_c0 | w_c1;
  assign w_last  = (r_cnt == CW'(WIDTH - 1));

  // Shift-right with the new bit at the MSB; written this way so WIDTH=1 needs no special slice.
  always_comb begin
    w_sum_shift            = r_sum >> 1;
    w_sum_shift[WIDTH-1]   = w_s;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = SHIFT;
      SHIFT:   if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_c     <= 1'b0;
      r_carry <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a   <= input_a;
            r_b   <= input_b;
            r_c   <= 1'b0;
            r_cnt <= '0;
          end
        end
        SHIFT: begin
          r_sum <= w_sum_shift;
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_c   <= w_cnext;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_carry <= w_cnext;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            // r_c is the carry into the MSB at this point
            r_ovf   <= r_c ^ w_cnext;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign sum   = r_sum;
  assign carry = r_carry;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  assign overflow = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8 main instance plus a WIDTH=1 instance).
// Overflow checks are active when SERIAL_ADDER_OVERFLOW_EN is defined.

module tb_serial_adder;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         start, start1;
  logic [W-1:0] input_a, input_b;
  logic [0:0]   a1, b1;
  logic [W-1:0] sum;
  logic [0:0]   sum1;
  logic         carry, busy, done, carry1, busy1, done1;
  logic         overflow, overflow1;

  int n_tests = 0;
  int n_fail  = 0;
  int dcount  = 0;

  always #5 clock = ~clock;

  serial_adder #(.WIDTH(W)) u_dut (
    .clock(clock), .reset(reset), .start(start),
    .input_a(input_a), .input_b(input_b),
    .sum(sum), .carry(carry),
`ifdef SERIAL_ADDER_OVERFLOW_EN
    .overflow(overflow),
`endif
    .busy(busy), .done(done)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clock(clock), .reset(reset), .start(start1),
    .input_a(a1), .input_b(b1),
    .sum(sum1), .carry(carry1),
`ifdef SERIAL_ADDER_OVERFLOW_EN
    .overflow(overflow1),
`endif
    .busy(busy1), .done(done1)
  );

`ifndef SERIAL_ADDER_OVERFLOW_EN
  assign overflow  = 1'b0;
  assign overflow1 = 1'b0;
`endif

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: result = a+b computed at acceptance, revealed WIDTH edges later.
  logic [3:0]   m_left = '0;
  logic         m_done = 1'b0;
  logic [W:0]   m_res  = '0;
  logic         m_ovf_n = 1'b0;
  logic [W-1:0] m_sum  = '0;
  logic         m_carry = 1'b0;
  logic         m_ovf  = 1'b0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_left  <= '0;
      m_done  <= 1'b0;
      m_sum   <= '0;
      m_carry <= 1'b0;
      m_ovf   <= 1'b0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_left != 0) begin
      m_left <= m_left - 4'd1;
      if (m_left == 4'd1) begin
        m_done  <= 1'b1;
        m_sum   <= m_res[W-1:0];
        m_carry <= m_res[W];
        m_ovf   <= m_ovf_n;
      end
    end else if (start) begin
      m_left  <= 4'(W);
      m_res   <= {1'b0, input_a} + {1'b0, input_b};
      m_ovf_n <= (input_a[W-1] == input_b[W-1]) &&
                 (((input_a + input_b) >> (W-1)) & 1) != input_a[W-1];
    end
  end

  always @(negedge clock) begin
    chk("busy", busy, m_left != 0);
    chk("done", done, m_done);
    if (m_left == 0) begin
      chk("sum", sum, m_sum);
      chk("carry", carry, m_carry);
`ifdef SERIAL_ADDER_OVERFLOW_EN
      chk("overflow", overflow, m_ovf);
`endif
    end
    if (done) dcount++;
  end

  task automatic wait_done(input string nm, input int exp_n, input int n0);
    int n;
    n = n0;
    while (!done && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk({nm, "_latency"}, n, exp_n);
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] es, input logic ec, input logic eo);
    input_a = a;
    input_b = b;
    start   = 1'b1;
    @(negedge clock);
    start   = 1'b0;
    wait_done(nm, 9, 1);
    chk({nm, "_sum"}, sum, es);
    chk({nm, "_carry"}, carry, ec);
`ifdef SERIAL_ADDER_OVERFLOW_EN
    chk({nm, "_ovf"}, overflow, eo);
`else
    if (eo === 1'bx) chk({nm, "_ovf_x"}, eo, 0);
`endif
    @(negedge clock);
  endtask

  task automatic run_w1(input string nm, input logic a, input logic b,
                        input logic es, input logic ec, input logic eo);
    int n;
    a1 = a;
    b1 = b;
    start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0;
    n = 1;
    while (!done1 && n < 10) begin
      @(negedge clock);
      n++;
    end
    chk({nm, "_latency"}, n, 2);
    chk({nm, "_sum"}, sum1, es);
    chk({nm, "_carry"}, carry1, ec);
`ifdef SERIAL_ADDER_OVERFLOW_EN
    chk({nm, "_ovf"}, overflow1, eo);
`else
    if (eo === 1'bx) chk({nm, "_ovf_x"}, eo, 0);
`endif
    @(negedge clock);
  endtask

  initial begin
    int d0;
    reset = 1'b0; start = 1'b0; start1 = 1'b0;
    input_a = '0; input_b = '0; a1 = '0; b1 = '0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_carry", carry, 0);
    reset = 1'b0;
    @(negedge clock);

    run_op("basic", 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0);
    run_op("ripple", 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    run_op("sovf", 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);

    // start pulse during SHIFT must be ignored
    d0 = dcount;
    input_a = 8'h12; input_b = 8'h34; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    input_a = 8'h00; input_b = 8'h00; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done("ignore", 9, 4);
    chk("ignore_sum", sum, 8'h46);
    repeat (14) @(negedge clock);
    chk("ignore_one_done", dcount - d0, 1);

    // asynchronous reset between the 3rd and 4th SHIFT edges
    input_a = 8'hAA; input_b = 8'h55; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    #1 reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_sum", sum, 0);
    chk("abort_carry", carry, 0);
    chk("abort_done", done, 0);
    @(negedge clock);
    reset = 1'b0;
    d0 = dcount;
    repeat (12) @(negedge clock);
    chk("abort_no_done", dcount - d0, 0);
    run_op("after_abort", 8'h01, 8'h02, 8'h03, 1'b0, 1'b0);

    // start held high: re-accepted on the first IDLE edge
    input_a = 8'h10; input_b = 8'h20; start = 1'b1;
    @(negedge clock);
    wait_done("b2b1", 9, 1);
    chk("b2b1_sum", sum, 8'h30);
    chk("b2b1_carry", carry, 0);
    input_a = 8'h80; input_b = 8'h80;
    @(negedge clock);
    chk("b2b_idle", busy, 0);
    @(negedge clock);
    chk("b2b_accept", busy, 1);
    start = 1'b0;
    wait_done("b2b2", 9, 1);
    chk("b2b2_sum", sum, 8'h00);
    chk("b2b2_carry", carry, 1);
    @(negedge clock);

    run_w1("w1_11", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    run_w1("w1_10", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    repeat (2) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
